// File: rtl/event_pulse_generator.sv
// Scheduled event-line driver: accepts (op, delay, width) commands and applies set/clear/toggle/pulse actions on event_out.
// Optional EVENT_GEN_COUNT_EN adds the event_count port counting every strobed action or restore.
//
// state | meaning
// IDLE  | ready for a command, event_out static
// WAIT  | counting down cmd_delay before the action
// HOLD  | pulse level inverted, counting down the pulse width before restore
module event_pulse_generator #(
    parameter int DELAY_WIDTH = 8,
    parameter int WIDTH_WIDTH = 8,
    parameter bit INIT_LEVEL  = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [DELAY_WIDTH-1:0] cmd_delay,
    input  logic [WIDTH_WIDTH-1:0] cmd_width,
    input  logic                   cmd_abort,
    output logic                   event_out,
    output logic                   event_strobe,
`ifdef EVENT_GEN_COUNT_EN
    output logic [COUNT_WIDTH-1:0] event_count,
`endif
    output logic                   busy
);

    localparam int CNT_W = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [1:0] OP_SET_HIGH = 2'd0;
    localparam logic [1:0] OP_SET_LOW  = 2'd1;
    localparam logic [1:0] OP_PULSE    = 2'd3;

    logic [1:0]             state;
    logic [1:0]             op_q;
    logic [WIDTH_WIDTH-1:0] width_q;
    logic [CNT_W-1:0]       counter;
    logic [CNT_W-1:0]       pulse_len_m1;
    logic                   cnt_zero;
    logic                   action_now;
    logic                   restore_now;

    assign cmd_ready = (state == IDLE) && reset_n;
    assign busy      = (state != IDLE);
    assign cnt_zero  = (counter == '0);

    // A zero width still produces a one-cycle pulse.
    assign pulse_len_m1 = (width_q == '0) ? '0 : CNT_W'(width_q) - CNT_W'(1);

    always_comb begin
        action_now  = (state == WAIT) && !cmd_abort && cnt_zero;
        restore_now = (state == HOLD) && (cmd_abort || cnt_zero);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            event_out    <= INIT_LEVEL;
            event_strobe <= 1'b0;
            counter      <= '0;
            op_q         <= OP_SET_HIGH;
            width_q      <= '0;
        end else begin
            event_strobe <= action_now || restore_now;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        width_q <= cmd_width;
                        counter <= CNT_W'(cmd_delay);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cmd_abort) begin
                        state <= IDLE;
                    end else if (!cnt_zero) begin
                        counter <= counter - CNT_W'(1);
                    end else begin
                        if (op_q == OP_SET_HIGH) begin
                            event_out <= 1'b1;
                        end else if (op_q == OP_SET_LOW) begin
                            event_out <= 1'b0;
                        end else begin
                            event_out <= ~event_out;
                        end
                        if (op_q == OP_PULSE) begin
                            counter <= pulse_len_m1;
                            state   <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    // Abort during a pulse still restores the line so it never stays inverted.
                    if (restore_now) begin
                        event_out <= ~event_out;
                        state     <= IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EVENT_GEN_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            event_count <= '0;
        end else if (action_now || restore_now) begin
            event_count <= event_count + COUNT_WIDTH'(1);
        end
    end
`else
    // COUNT_WIDTH only shapes the optional counter.
    if (COUNT_WIDTH > 0) begin : g_no_count
    end
`endif

endmodule
